// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register index/data word types and the
// fixed architectural constants used by the writeback stage and forwarding unit.
package mips_pkg;

  localparam int unsigned NREG     = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned REGIDX_W = 5;

  typedef logic [REGIDX_W-1:0] regidx_t;
  typedef logic [DW-1:0]       word_t;

  localparam regidx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// 2:1 writeback select (load data vs ALU result); shared with the forwarding unit.
module wb_mux #(
  parameter int unsigned W = 32
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_alu,
  input  logic [W-1:0] i_mem,
  output logic [W-1:0] o_data
);

  assign o_data = i_sel ? i_mem : i_alu;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + 32x32 architectural register file with retired-write counter.
// Optional macro WB_REGFILE_BYPASS_EN: write-first bypass from WB onto qa/qb.
module wb_regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wwreg,
  input  logic                 wm2reg,
  input  mips_pkg::regidx_t    wmux_id_out,
  input  logic [DW-1:0]        walu_out,
  input  logic [DW-1:0]        wdmem_out,
  input  mips_pkg::regidx_t    rna,
  input  mips_pkg::regidx_t    rnb,
  output logic [DW-1:0]        qa,
  output logic [DW-1:0]        qb,
  output logic [DW-1:0]        wb_data,
  output logic                 wb_we,
  output logic [CNTW-1:0]      wb_count
);

  import mips_pkg::*;

  logic [DW-1:0]   r_regs [NREG];
  logic [CNTW-1:0] r_count;
  logic [DW-1:0]   w_wb_data;
  logic            w_wb_we;
  logic [DW-1:0]   w_qa_raw;
  logic [DW-1:0]   w_qb_raw;

  wb_mux #(.W(DW)) u_wb_mux (
    .i_sel  (wm2reg),
    .i_alu  (walu_out),
    .i_mem  (wdmem_out),
    .o_data (w_wb_data)
  );

  // Index 0 never asserts the write enable, so r_regs[0] stays at its reset value.
  assign w_wb_we = wwreg && (wmux_id_out != REG_ZERO);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
      r_count <= '0;
    end else if (w_wb_we) begin
      r_regs[wmux_id_out] <= w_wb_data;
      r_count             <= r_count + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign w_qa_raw = (rna == REG_ZERO) ? '0 : r_regs[rna];
  assign w_qb_raw = (rnb == REG_ZERO) ? '0 : r_regs[rnb];

`ifdef WB_REGFILE_BYPASS_EN
  // w_wb_we already excludes index 0, so register 0 still reads as zero.
  assign qa = (w_wb_we && (rna == wmux_id_out)) ? w_wb_data : w_qa_raw;
  assign qb = (w_wb_we && (rnb == wmux_id_out)) ? w_wb_data : w_qb_raw;
`else
  assign qa = w_qa_raw;
  assign qb = w_qb_raw;
`endif

  assign wb_data  = w_wb_data;
  assign wb_we    = w_wb_we;
  assign wb_count = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; counter width is narrowed so the
// wrap from all-ones to zero is reachable in a few hundred writes.
module tb_wb_regfile;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          resetn;
  logic          wwreg;
  logic          wm2reg;
  logic [4:0]    wmux_id_out;
  logic [31:0]   walu_out;
  logic [31:0]   wdmem_out;
  logic [4:0]    rna;
  logic [4:0]    rnb;
  logic [31:0]   qa;
  logic [31:0]   qb;
  logic [31:0]   wb_data;
  logic          wb_we;
  logic [CW-1:0] wb_count;

  int n_total;
  int n_bad;

  wb_regfile #(.NREG(32), .DW(32), .CNTW(CW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wwreg       (wwreg),
    .wm2reg      (wm2reg),
    .wmux_id_out (wmux_id_out),
    .walu_out    (walu_out),
    .wdmem_out   (wdmem_out),
    .rna         (rna),
    .rnb         (rnb),
    .qa          (qa),
    .qb          (qb),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .wb_count    (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] idx, input logic m2r,
                          input logic [31:0] alu, input logic [31:0] mem);
    wwreg       = 1'b1;
    wm2reg      = m2r;
    wmux_id_out = idx;
    walu_out    = alu;
    wdmem_out   = mem;
    tick();
    wwreg = 1'b0;
    $display("txn write r%0d m2reg=%0d alu=0x%08h mem=0x%08h count=%0d",
             idx, m2r, alu, mem, wb_count);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    resetn = 1'b0; wwreg = 1'b0; wm2reg = 1'b0; wmux_id_out = '0;
    walu_out = '0; wdmem_out = '0; rna = 5'd5; rnb = 5'd31;

    #12;
    chk("reset_qa", qa, 32'h0);
    chk("reset_qb", qb, 32'h0);
    chk("reset_count", 32'(wb_count), 32'd0);
    resetn = 1'b1;
    #1;

    // ALU result write to r5
    wwreg = 1'b1; wm2reg = 1'b0; wmux_id_out = 5'd5;
    walu_out = 32'h1234_5678; wdmem_out = 32'hABCD_0000;
    #1;
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    chk("alu_wb_we", 32'(wb_we), 32'd1);
    do_write(5'd5, 1'b0, 32'h1234_5678, 32'hABCD_0000);
    rna = 5'd5;
    #1;
    chk("alu_qa_r5", qa, 32'h1234_5678);
    chk("alu_count", 32'(wb_count), 32'd1);

    // Load data write to r31
    wwreg = 1'b1; wm2reg = 1'b1; wmux_id_out = 5'd31;
    walu_out = 32'h0; wdmem_out = 32'hDEAD_BEEF;
    #1;
    chk("load_wb_data", wb_data, 32'hDEAD_BEEF);
    do_write(5'd31, 1'b1, 32'h0, 32'hDEAD_BEEF);
    rnb = 5'd31;
    #1;
    chk("load_qb_r31", qb, 32'hDEAD_BEEF);
    chk("load_count", 32'(wb_count), 32'd2);

    // Writes to r0 are dropped, even on the bypass path
    wwreg = 1'b1; wm2reg = 1'b0; wmux_id_out = 5'd0; walu_out = 32'hFFFF_FFFF;
    rna = 5'd0;
    #1;
    chk("zero_wb_we", 32'(wb_we), 32'd0);
    chk("zero_qa_inflight", qa, 32'h0);
    do_write(5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    chk("zero_qa_after", qa, 32'h0);
    chk("zero_count", 32'(wb_count), 32'd2);

    // Same-cycle read-after-write on r7
    do_write(5'd7, 1'b0, 32'h11, 32'h0);
    wwreg = 1'b1; wm2reg = 1'b0; wmux_id_out = 5'd7; walu_out = 32'h22;
    rna = 5'd7; rnb = 5'd7;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    chk("raw_qa_same_cycle", qa, 32'h22);
    chk("raw_qb_same_cycle", qb, 32'h22);
`else
    chk("raw_qa_same_cycle", qa, 32'h11);
    chk("raw_qb_same_cycle", qb, 32'h11);
`endif
    do_write(5'd7, 1'b0, 32'h22, 32'h0);
    chk("raw_qa_next_cycle", qa, 32'h22);
    chk("raw_count", 32'(wb_count), 32'd4);

    // Write to a different index does not disturb reads
    wwreg = 1'b1; wm2reg = 1'b0; wmux_id_out = 5'd9; walu_out = 32'h99;
    rna = 5'd5; rnb = 5'd31;
    #1;
    chk("diff_qa_r5", qa, 32'h1234_5678);
    chk("diff_qb_r31", qb, 32'hDEAD_BEEF);
    do_write(5'd9, 1'b0, 32'h99, 32'h0);
    rna = 5'd9;
    #1;
    chk("diff_qa_r9", qa, 32'h99);

    // wwreg low with random payload: no state or counter change
    for (int k = 0; k < 10; k++) begin
      wwreg = 1'b0; wm2reg = 1'($urandom);
      wmux_id_out = 5'($urandom); walu_out = $urandom; wdmem_out = $urandom;
      tick();
    end
    rna = 5'd7; rnb = 5'd31;
    #1;
    chk("idle_qa_r7", qa, 32'h22);
    chk("idle_qb_r31", qb, 32'hDEAD_BEEF);
    chk("idle_count", 32'(wb_count), 32'd5);

    // Counter wrap: 5 + 250 = 255 = all ones, one more wraps to 0
    wwreg = 1'b1; wm2reg = 1'b0; wmux_id_out = 5'd3;
    for (int k = 0; k < 250; k++) begin
      walu_out = 32'(k);
      tick();
    end
    wwreg = 1'b0;
    rna = 5'd3;
    #1;
    chk("wrap_count_max", 32'(wb_count), 32'd255);
    chk("wrap_qa_r3", qa, 32'd249);
    do_write(5'd3, 1'b0, 32'hC0FFEE, 32'h0);
    chk("wrap_count_zero", 32'(wb_count), 32'd0);

    // Asynchronous reset mid-cycle with a write in flight
    wwreg = 1'b1; wm2reg = 1'b0; wmux_id_out = 5'd4; walu_out = 32'h44;
    #1;
    resetn = 1'b0;
    #1;
    chk("areset_count", 32'(wb_count), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(31 - i);
      #1;
      chk($sformatf("areset_qa_r%0d", i), qa, 32'h0);
      chk($sformatf("areset_qb_r%0d", 31 - i), qb, 32'h0);
    end
    tick();
    wwreg = 1'b0;
    #2;
    resetn = 1'b1;
    rna = 5'd4;
    #1;
    chk("inflight_qa_r4", qa, 32'h0);

    // First write lands on the first edge after release
    do_write(5'd6, 1'b0, 32'h66, 32'h0);
    rna = 5'd6;
    #1;
    chk("post_reset_qa_r6", qa, 32'h66);
    chk("post_reset_count", 32'(wb_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs, selects ALU result or load data, and commits it to a 32x32 register file.
- Supplies the two ID-stage read ports (rs/rt) and a retired-write counter.
- Sits at the tail of the pipeline and feeds ID, closing the register dataflow loop.

Parameters:
- NREG, 32, number of architectural registers (power of two, index width = log2(NREG) = 5)
- DW, 32, datapath width
- CNTW, 32, width of retired-write counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- wwreg  in  1  WB-stage register-write enable
- wm2reg  in  1  1 = write load data, 0 = write ALU result
- wmux_id_out  in  5  WB-stage destination register index
- walu_out  in  DW  WB-stage ALU result
- wdmem_out  in  DW  WB-stage data-memory read data
- rna  in  5  ID read index A (rs)
- rnb  in  5  ID read index B (rt)
- qa  out  DW  read data A
- qb  out  DW  read data B
- wb_data  out  DW  selected writeback value, combinational, for EX/ID forwarding
- wb_we  out  1  qualified write enable = wwreg and (wmux_id_out != 0)
- wb_count  out  CNTW  number of committed register writes since reset

Behaviour:
- Reset:
  - Asserting resetn low asynchronously clears all NREG registers and wb_count to 0.
  - Deassertion is sampled synchronously; the first write can occur on the first rising edge after resetn is high.
  - Reset during an in-flight write discards that write.
- Writeback mux (combinational): wb_data = wm2reg ? wdmem_out : walu_out.
- Write:
  - On a rising edge with wb_we = 1, reg[wmux_id_out] <= wb_data.
  - Latency 1 cycle from WB inputs to architectural state.
- Register 0:
  - Hardwired to zero. Writes to index 0 are dropped (wb_we = 0) and do not count.
  - Reads of index 0 always return 0, including under bypass.
- Reads: qa/qb are combinational from rna/rnb and current state. Both ports are independent; rna == rnb is legal and returns identical data.
- wb_count:
  - Increments by 1 on every rising edge with wb_we = 1.
  - Wraps from 2^CNTW-1 to 0 without a flag.
- Simultaneous events:
  - A write and reads of a different index in the same cycle do not interact.
  - Same-index read behaviour is defined under Optional Feature.
- Unknowns: with wwreg = 0, wm2reg/wmux_id_out/data are don't-care and must not alter state or the counter.
- There is no stall input. The MEM/WB register upstream is free-running, so every cycle presents a new WB slot.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN
- Defined:
  - Write-first internal bypass.
  - If wb_we = 1 and rna == wmux_id_out (non-zero), then qa = wb_data in the same cycle; likewise for qb with rnb.
  - ID therefore sees a value written by WB in the same cycle without an extra forwarding path.
- Undefined:
  - qa/qb return pre-write contents.
  - The new value is visible from the cycle after the edge, so the hazard unit must forward wb_data or stall one cycle.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ZERO = 5'd0
  - constants NREG, DW, REGIDX_W = 5
  - a typedef for the register index and the data word
- One natural sub-module: wb_mux (2:1 DW-wide writeback select), reused by the forwarding unit.
- Register array and counter stay in wb_regfile.

Test Plan:
- Reset: drive resetn=0 mid-simulation after several writes -> qa=qb=0 for all indices 0..31, wb_count=0 immediately, without waiting for a clock edge.
- ALU write: wwreg=1, wm2reg=0, wmux_id_out=5, walu_out=0x1234_5678 for one edge; then rna=5 -> qa=0x1234_5678, wb_count=1.
- Load write: wwreg=1, wm2reg=1, wmux_id_out=31, wdmem_out=0xDEAD_BEEF, walu_out=0x0 -> reg31=0xDEAD_BEEF, wb_data=0xDEAD_BEEF during the cycle.
- Zero register: wwreg=1, wmux_id_out=0, walu_out=0xFFFF_FFFF -> wb_we=0, qa(rna=0)=0, wb_count unchanged.
- Same-cycle read-after-write on reg 7 (old 0x11, new 0x22):
  - with WB_REGFILE_BYPASS_EN: qa=0x22 in the write cycle;
  - without: qa=0x11 in the write cycle, 0x22 the next cycle.
- Counter wrap: force wb_count to 0xFFFF_FFFF, then one valid write -> wb_count=0. Also, wwreg=0 for 10 cycles with random data -> no state change.
